// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: independent read/write FSMs, INCR/FIXED bursts, byte strobes; first R beat READ_LAT cycles after AR, R beats held under !rready.
// Optional AXI_SLAVE_MEM_RANGE_ERR_EN: bursts running past DEPTH answer SLVERR (reads return 0, writes dropped).
module axi_slave_mem #(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int DEPTH    = 1024,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);
  localparam int NB     = DATA_W / 8;
  localparam int OFF    = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int FULL_W = ADDR_W - OFF;
  localparam int LAT_W  = $clog2(READ_LAT + 1);

  typedef enum logic [1:0] {R_IDLE, R_LAT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  r_state_t          r_state, r_next;
  logic [ID_W-1:0]   r_id;
  logic [IDX_W-1:0]  r_idx, r_idx_nxt;
  logic [7:0]        r_len, r_beat;
  logic [LAT_W-1:0]  r_cnt;
  logic              r_fixed, r_err, ar_err;
  logic              ar_hs, r_hs, r_last_beat;

  w_state_t          w_state, w_next;
  logic [IDX_W-1:0]  w_idx;
  logic [7:0]        w_len, w_beat;
  logic              w_fixed, w_err, aw_err;
  logic              aw_hs, w_hs;

  // Size, wlast and the byte-offset/upper address bits carry no information here.
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axi_awsize, s_axi_arsize, s_axi_wlast, s_axi_awaddr, s_axi_araddr};

`ifdef AXI_SLAVE_MEM_RANGE_ERR_EN
  logic [FULL_W:0] ar_end, aw_end;
  assign ar_end = {1'b0, s_axi_araddr[ADDR_W-1:OFF]}
                + (FULL_W+1)'((s_axi_arburst == 2'd0) ? 8'd0 : s_axi_arlen);
  assign aw_end = {1'b0, s_axi_awaddr[ADDR_W-1:OFF]}
                + (FULL_W+1)'((s_axi_awburst == 2'd0) ? 8'd0 : s_axi_awlen);
  assign ar_err = (ar_end >= (FULL_W+1)'(DEPTH));
  assign aw_err = (aw_end >= (FULL_W+1)'(DEPTH));
`else
  assign ar_err = 1'b0;
  assign aw_err = 1'b0;
`endif

  // ---------------- read channel ----------------
  assign ar_hs       = s_axi_arvalid & s_axi_arready;
  assign r_hs        = s_axi_rvalid & s_axi_rready;
  assign r_last_beat = (r_beat == r_len);
  assign r_idx_nxt   = r_fixed ? r_idx : r_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = R_LAT;
      R_LAT:   if (r_cnt == LAT_W'(1)) r_next = R_DATA;
      R_DATA:  if (r_hs && r_last_beat) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rlast   <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rid     <= '0;
      s_axi_rresp   <= 2'd0;
      r_id          <= '0;
      r_idx         <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_cnt         <= '0;
      r_fixed       <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      s_axi_arready <= (r_next == R_IDLE);
      case (r_state)
        R_IDLE: if (ar_hs) begin
          r_id    <= s_axi_arid;
          r_idx   <= s_axi_araddr[OFF +: IDX_W];
          r_len   <= s_axi_arlen;
          r_beat  <= 8'd0;
          r_fixed <= (s_axi_arburst == 2'd0);
          r_err   <= ar_err;
          r_cnt   <= LAT_W'(READ_LAT);
        end
        R_LAT: begin
          r_cnt <= r_cnt - LAT_W'(1);
          if (r_cnt == LAT_W'(1)) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= r_err ? '0 : mem[r_idx];
            s_axi_rid    <= r_id;
            s_axi_rresp  <= r_err ? 2'd2 : 2'd0;
            s_axi_rlast  <= (r_len == 8'd0);
          end
        end
        R_DATA: if (r_hs) begin
          if (r_last_beat) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rlast  <= 1'b0;
          end else begin
            // Next beat is fetched on the handshake edge so R streams without bubbles.
            r_idx       <= r_idx_nxt;
            r_beat      <= r_beat + 8'd1;
            s_axi_rdata <= r_err ? '0 : mem[r_idx_nxt];
            s_axi_rlast <= ((r_beat + 8'd1) == r_len);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- write channel ----------------
  assign aw_hs        = s_axi_awvalid & s_axi_awready;
  assign w_hs         = s_axi_wvalid & s_axi_wready;
  assign s_axi_wready = (w_state == W_DATA);
  assign s_axi_bvalid = (w_state == W_RESP);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && (w_beat == w_len)) w_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      s_axi_awready <= 1'b0;
      s_axi_bid     <= '0;
      s_axi_bresp   <= 2'd0;
      w_idx         <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_fixed       <= 1'b0;
      w_err         <= 1'b0;
    end else begin
      s_axi_awready <= (w_next == W_IDLE);
      if (aw_hs) begin
        w_idx       <= s_axi_awaddr[OFF +: IDX_W];
        w_len       <= s_axi_awlen;
        w_beat      <= 8'd0;
        w_fixed     <= (s_axi_awburst == 2'd0);
        w_err       <= aw_err;
        s_axi_bid   <= s_axi_awid;
        s_axi_bresp <= aw_err ? 2'd2 : 2'd0;
      end else if (w_hs) begin
        w_beat <= w_beat + 8'd1;
        w_idx  <= w_fixed ? w_idx : w_idx + IDX_W'(1);
      end
    end
  end

  // Storage has no reset so contents survive an aresetn pulse.
  always_ff @(posedge clk) begin
    if (w_hs && !w_err) begin
      for (int b = 0; b < NB; b++) begin
        if (s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: directed scenarios plus randomized bursts against a word-array model.
module tb_axi_slave_mem;
  localparam int DEPTH = 1024;
  localparam int LAT   = 3;
`ifdef AXI_SLAVE_MEM_RANGE_ERR_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        aresetn;
  logic [3:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [27:0] s_axi_awaddr, s_axi_araddr;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [3:0]  s_axi_wstrb;

  always #5 clk = ~clk;

  axi_slave_mem #(.ADDR_W(28), .DATA_W(32), .ID_W(4), .DEPTH(DEPTH), .READ_LAT(LAT)) dut (
    .clk(clk), .aresetn(aresetn),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic [31:0] rbuf [256];
  logic        rlast_buf [256];
  logic [1:0]  rresp_buf [256];
  logic [3:0]  rid_buf [256];
  logic [31:0] exp_d [256];
  logic [1:0]  exp_r [256];
  int          rd_lat, hold_viol, bubbles;
  logic        post_rvalid, post_arready, post_awready, wr_bvalid_imm;
  logic [1:0]  wr_resp;
  logic [3:0]  wr_bid;

  // ---------------- reference model ----------------
  function automatic bit model_err(input int full, input int len, input logic [1:0] burst);
    int last_idx;
    last_idx = (burst == 2'd0) ? full : full + len;
    return RANGE_CHK && (last_idx >= DEPTH);
  endfunction

  function automatic void model_write(input int full, input int len, input logic [1:0] burst);
    if (model_err(full, len, burst)) return;
    for (int i = 0; i <= len; i++) begin
      int idx;
      idx = ((burst == 2'd0) ? full : full + i) % DEPTH;
      for (int b = 0; b < 4; b++)
        if (sbuf[i][b]) model_mem[idx][b*8 +: 8] = wbuf[i][b*8 +: 8];
    end
  endfunction

  function automatic void model_read(input int full, input int len, input logic [1:0] burst);
    bit e;
    e = model_err(full, len, burst);
    for (int i = 0; i <= len; i++) begin
      exp_d[i] = e ? 32'd0 : model_mem[((burst == 2'd0) ? full : full + i) % DEPTH];
      exp_r[i] = e ? 2'd2 : 2'd0;
    end
  endfunction

  // ---------------- bus drivers ----------------
  task automatic axi_write(input logic [27:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id, output bit ok);
    int t;
    ok = 1'b1;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = 3'd2;
    s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    t = 0;
    while (!s_axi_awready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) begin ok = 1'b0; s_axi_awvalid = 1'b0; return; end
    @(posedge clk); #1;
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      s_axi_wdata = wbuf[i]; s_axi_wstrb = sbuf[i]; s_axi_wlast = (i == int'(len)); s_axi_wvalid = 1'b1;
      t = 0;
      while (!s_axi_wready && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) begin ok = 1'b0; s_axi_wvalid = 1'b0; return; end
      @(posedge clk); #1;
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    wr_bvalid_imm = s_axi_bvalid;
    s_axi_bready = 1'b1;
    t = 0;
    while (!s_axi_bvalid && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) begin ok = 1'b0; s_axi_bready = 1'b0; return; end
    wr_resp = s_axi_bresp; wr_bid = s_axi_bid;
    @(posedge clk); #1;
    s_axi_bready = 1'b0;
    post_awready = s_axi_awready;
  endtask

  // mode 0: rready always 1, 1: toggling 1,0,1,0..., 2: random
  task automatic axi_read(input logic [27:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [3:0] id, input int mode, output bit ok);
    int t, n;
    bit hs, stall;
    logic [31:0] hold_d;
    ok = 1'b1; hold_viol = 0; bubbles = 0;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = 3'd2;
    s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 50) begin @(posedge clk); #1; t++; end
    if (t >= 50) begin ok = 1'b0; s_axi_arvalid = 1'b0; return; end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    rd_lat = 0;
    while (!s_axi_rvalid && rd_lat < 50) begin @(posedge clk); #1; rd_lat++; end
    if (rd_lat >= 50) begin ok = 1'b0; return; end
    n = 0; t = 0;
    while (n <= int'(len) && t < 2000) begin
      case (mode)
        0:       s_axi_rready = 1'b1;
        1:       s_axi_rready = (t % 2 == 0);
        default: s_axi_rready = 1'($urandom_range(0, 1));
      endcase
      hs = s_axi_rvalid && s_axi_rready;
      stall = s_axi_rvalid && !s_axi_rready;
      hold_d = s_axi_rdata;
      if (!s_axi_rvalid) bubbles++;
      if (hs) begin
        rbuf[n] = s_axi_rdata; rlast_buf[n] = s_axi_rlast;
        rresp_buf[n] = s_axi_rresp; rid_buf[n] = s_axi_rid;
        n++;
      end
      @(posedge clk); #1; t++;
      if (stall && (!s_axi_rvalid || s_axi_rdata !== hold_d)) hold_viol++;
    end
    s_axi_rready = 1'b0;
    post_rvalid = s_axi_rvalid;
    post_arready = s_axi_arready;
    ok = (n > int'(len));
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    aresetn = 1'b0;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; s_axi_arvalid = 0; s_axi_rready = 0;
    s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awsize = 0; s_axi_awburst = 0;
    s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0;
    s_axi_arid = 0; s_axi_araddr = 0; s_axi_arlen = 0; s_axi_arsize = 0; s_axi_arburst = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_rlast, s_axi_bvalid} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ar/aw/w/rv/rl/bv=%b expected 000000",
               {s_axi_arready, s_axi_awready, s_axi_wready, s_axi_rvalid, s_axi_rlast, s_axi_bvalid});
    end
    n_checks++;
    if ({s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_bid, s_axi_bresp} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset_data: rdata=%h rid=%h rresp=%h bid=%h bresp=%h expected all 0",
               s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_bid, s_axi_bresp);
    end
    aresetn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({s_axi_arready, s_axi_awready} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release: arready=%b awready=%b expected 1 1", s_axi_arready, s_axi_awready);
    end
  endtask

  task automatic test_single();
    bit ok;
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    axi_write(28'h10, 8'd0, 2'd1, 4'h3, ok);
    model_write(4, 0, 2'd1);
    n_checks++;
    if (!ok || wr_resp !== 2'd0 || wr_bid !== 4'h3) begin
      n_fail++;
      $display("FAIL single_wr: ok=%0d bresp=%0d bid=%0d expected ok=1 bresp=0 bid=3", ok, wr_resp, wr_bid);
    end
    n_checks++;
    if (wr_bvalid_imm !== 1'b1 || post_awready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_b_timing: bvalid_after_last_w=%b awready_after_b=%b expected 1 1",
               wr_bvalid_imm, post_awready);
    end
    axi_read(28'h10, 8'd0, 2'd1, 4'h9, 0, ok);
    n_checks++;
    if (!ok || rd_lat != LAT) begin
      n_fail++;
      $display("FAIL single_rd_lat: ok=%0d latency=%0d expected %0d", ok, rd_lat, LAT);
    end
    n_checks++;
    if (rbuf[0] !== 32'hDEADBEEF || rlast_buf[0] !== 1'b1 || rid_buf[0] !== 4'h9 || rresp_buf[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL single_rd: rdata=%h rlast=%b rid=%h rresp=%0d expected deadbeef 1 9 0",
               rbuf[0], rlast_buf[0], rid_buf[0], rresp_buf[0]);
    end
    n_checks++;
    if (post_rvalid !== 1'b0 || post_arready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_rd_end: rvalid=%b arready=%b expected 0 1", post_rvalid, post_arready);
    end
  endtask

  task automatic test_incr_toggle();
    bit ok;
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    axi_write(28'h100, 8'd3, 2'd1, 4'h1, ok);
    model_write(28'h100 / 4, 3, 2'd1);
    n_checks++;
    if (!ok || wr_resp !== 2'd0) begin
      n_fail++;
      $display("FAIL incr_wr: ok=%0d bresp=%0d expected 1 0", ok, wr_resp);
    end
    axi_read(28'h100, 8'd3, 2'd1, 4'h2, 1, ok);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (!ok || rbuf[i] !== 32'(i + 1) || rlast_buf[i] !== (i == 3)) begin
        n_fail++;
        $display("FAIL incr_rd beat %0d: rdata=%h rlast=%b expected %h %b", i, rbuf[i], rlast_buf[i], i + 1, i == 3);
      end
    end
    n_checks++;
    if (hold_viol != 0) begin
      n_fail++;
      $display("FAIL incr_hold: %0d stalled beats changed, expected 0", hold_viol);
    end
  endtask

  task automatic test_strobe();
    bit ok;
    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
    axi_write(28'h200, 8'd0, 2'd1, 4'h0, ok);
    wbuf[0] = 32'h00000000; sbuf[0] = 4'h5;
    axi_write(28'h200, 8'd0, 2'd1, 4'h0, ok);
    sbuf[0] = 4'hF; wbuf[0] = 32'hFF00FF00;
    model_write(28'h200 / 4, 0, 2'd1);
    axi_read(28'h200, 8'd0, 2'd1, 4'h4, 0, ok);
    n_checks++;
    if (!ok || rbuf[0] !== 32'hFF00FF00) begin
      n_fail++;
      $display("FAIL strobe: rdata=%h expected ff00ff00", rbuf[0]);
    end
  endtask

  task automatic test_fill();
    bit ok;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      axi_write(28'(c * 1024), 8'd255, 2'd1, 4'(c), ok);
      model_write(c * 256, 255, 2'd1);
      n_checks++;
      if (!ok || wr_resp !== 2'd0) begin
        n_fail++;
        $display("FAIL fill_wr chunk %0d: ok=%0d bresp=%0d expected 1 0", c, ok, wr_resp);
      end
    end
    for (int c = 1; c < 4; c += 2) begin
      model_read(c * 256, 255, 2'd1);
      axi_read(28'(c * 1024), 8'd255, 2'd1, 4'hA, 0, ok);
      for (int i = 0; i < 256; i++) begin
        n_checks++;
        if (!ok || rbuf[i] !== exp_d[i] || rlast_buf[i] !== (i == 255)) begin
          n_fail++;
          $display("FAIL fill_rd chunk %0d beat %0d: rdata=%h rlast=%b expected %h %b",
                   c, i, rbuf[i], rlast_buf[i], exp_d[i], i == 255);
        end
      end
      n_checks++;
      if (bubbles != 0) begin
        n_fail++;
        $display("FAIL fill_bubbles: %0d idle cycles inside burst, expected 0", bubbles);
      end
    end
  endtask

  task automatic test_concurrent();
    bit okw, okr;
    for (int i = 0; i < 8; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    model_read(600, 7, 2'd1);
    fork
      axi_write(28'(100 * 4), 8'd7, 2'd1, 4'h5, okw);
      axi_read(28'(600 * 4), 8'd7, 2'd1, 4'h6, 0, okr);
    join
    model_write(100, 7, 2'd1);
    n_checks++;
    if (!okw || !okr || wr_resp !== 2'd0) begin
      n_fail++;
      $display("FAIL conc_done: write_ok=%0d read_ok=%0d bresp=%0d expected 1 1 0", okw, okr, wr_resp);
    end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rbuf[i] !== exp_d[i] || rid_buf[i] !== 4'h6) begin
        n_fail++;
        $display("FAIL conc_rd beat %0d: rdata=%h rid=%h expected %h 6", i, rbuf[i], rid_buf[i], exp_d[i]);
      end
    end
    n_checks++;
    if (post_arready !== 1'b1 || post_awready !== 1'b1) begin
      n_fail++;
      $display("FAIL conc_ready: arready=%b awready=%b after final handshakes, expected 1 1",
               post_arready, post_awready);
    end
    model_read(100, 7, 2'd1);
    axi_read(28'(100 * 4), 8'd7, 2'd1, 4'h7, 0, okr);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (!okr || rbuf[i] !== exp_d[i]) begin
        n_fail++;
        $display("FAIL conc_wr_back beat %0d: rdata=%h expected %h", i, rbuf[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    int full, len;
    logic [1:0] burst;
    for (int it = 0; it < 24; it++) begin
      full = $urandom_range(0, DEPTH - 1); len = $urandom_range(0, 15); burst = 2'($urandom_range(0, 3));
      for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom_range(0, 15)); end
      axi_write(28'(full * 4), 8'(len), burst, 4'(it), ok);
      n_checks++;
      if (!ok || wr_resp !== (model_err(full, len, burst) ? 2'd2 : 2'd0) || wr_bid !== 4'(it)) begin
        n_fail++;
        $display("FAIL rand_wr %0d: ok=%0d bresp=%0d bid=%0d expected bresp=%0d bid=%0d",
                 it, ok, wr_resp, wr_bid, model_err(full, len, burst) ? 2 : 0, it % 16);
      end
      model_write(full, len, burst);
      full = $urandom_range(0, DEPTH - 1); len = $urandom_range(0, 15); burst = 2'($urandom_range(0, 3));
      model_read(full, len, burst);
      axi_read(28'(full * 4), 8'(len), burst, 4'(~it), 2, ok);
      for (int i = 0; i <= len; i++) begin
        n_checks++;
        if (!ok || rbuf[i] !== exp_d[i] || rresp_buf[i] !== exp_r[i] || rlast_buf[i] !== (i == len)) begin
          n_fail++;
          $display("FAIL rand_rd %0d beat %0d: rdata=%h rresp=%0d rlast=%b expected %h %0d %b",
                   it, i, rbuf[i], rresp_buf[i], rlast_buf[i], exp_d[i], exp_r[i], i == len);
        end
      end
      n_checks++;
      if (hold_viol != 0) begin
        n_fail++;
        $display("FAIL rand_hold %0d: %0d stalled beats changed, expected 0", it, hold_viol);
      end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(28'(1022 * 4), 8'd3, 2'd1, 4'h2, ok);
    n_checks++;
    if (!ok || wr_resp !== (model_err(1022, 3, 2'd1) ? 2'd2 : 2'd0)) begin
      n_fail++;
      $display("FAIL wrap_wr: ok=%0d bresp=%0d expected %0d", ok, wr_resp, model_err(1022, 3, 2'd1) ? 2 : 0);
    end
    model_write(1022, 3, 2'd1);
    model_read(1022, 3, 2'd1);
    axi_read(28'(1022 * 4), 8'd3, 2'd1, 4'h3, 0, ok);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (!ok || rbuf[i] !== exp_d[i] || rresp_buf[i] !== exp_r[i]) begin
        n_fail++;
        $display("FAIL wrap_rd beat %0d: rdata=%h rresp=%0d expected %h %0d", i, rbuf[i], rresp_buf[i], exp_d[i], exp_r[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit ok;
    int t;
    s_axi_arid = 4'h4; s_axi_araddr = 28'(40 * 4); s_axi_arlen = 8'd7; s_axi_arsize = 3'd2;
    s_axi_arburst = 2'd1; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    t = 0;
    while (!s_axi_arready && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    while (!s_axi_rvalid && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (t >= 100 || s_axi_rvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_setup: rvalid=%b at beat 2 expected 1", s_axi_rvalid);
    end
    aresetn = 1'b0;
    #1;
    n_checks++;
    if ({s_axi_rvalid, s_axi_rlast, s_axi_arready} !== 3'b000 || s_axi_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid_async: rvalid=%b rlast=%b arready=%b rdata=%h expected 0 0 0 0",
               s_axi_rvalid, s_axi_rlast, s_axi_arready, s_axi_rdata);
    end
    s_axi_rready = 1'b0;
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (s_axi_arready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_release: arready=%b rvalid=%b expected 1 0", s_axi_arready, s_axi_rvalid);
    end
    model_read(40, 7, 2'd1);
    axi_read(28'(40 * 4), 8'd7, 2'd1, 4'h8, 0, ok);
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (!ok || rbuf[i] !== exp_d[i] || rlast_buf[i] !== (i == 7)) begin
        n_fail++;
        $display("FAIL rst_mid_reread beat %0d: rdata=%h rlast=%b expected %h %b",
                 i, rbuf[i], rlast_buf[i], exp_d[i], i == 7);
      end
    end
  endtask

`ifdef AXI_SLAVE_MEM_RANGE_ERR_EN
  task automatic test_range_err();
    bit ok;
    logic [31:0] old;
    old = model_mem[1023];
    for (int i = 0; i < 2; i++) begin wbuf[i] = ~old ^ 32'(i); sbuf[i] = 4'hF; end
    axi_write(28'(1023 * 4), 8'd1, 2'd1, 4'hC, ok);
    n_checks++;
    if (!ok || wr_resp !== 2'd2) begin
      n_fail++;
      $display("FAIL range_wr: ok=%0d bresp=%0d expected 1 2", ok, wr_resp);
    end
    axi_read(28'(1023 * 4), 8'd0, 2'd1, 4'hD, 0, ok);
    n_checks++;
    if (!ok || rbuf[0] !== old || rresp_buf[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL range_kept: rdata=%h rresp=%0d expected %h 0", rbuf[0], rresp_buf[0], old);
    end
    axi_read(28'(1023 * 4), 8'd1, 2'd1, 4'hE, 0, ok);
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (!ok || rbuf[i] !== 32'd0 || rresp_buf[i] !== 2'd2 || rlast_buf[i] !== (i == 1)) begin
        n_fail++;
        $display("FAIL range_rd beat %0d: rdata=%h rresp=%0d rlast=%b expected 0 2 %b",
                 i, rbuf[i], rresp_buf[i], rlast_buf[i], i == 1);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_incr_toggle();
    test_strobe();
    test_fill();
    test_concurrent();
    test_random();
    test_wrap();
    test_reset_mid_burst();
`ifdef AXI_SLAVE_MEM_RANGE_ERR_EN
    test_range_err();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_slave_mem.md
# axi_slave_mem

Synthesizable, parametrised AXI4 slave memory that replaces the bench-only single-beat read responder in front of `ucore_main`. It services independent read and write channels, INCR/FIXED bursts up to 256 beats, byte strobes and a programmable read latency, with real storage instead of random data. It is instanced in simulation benches and FPGA bring-up builds as the `m_axi_*` target of the microcoded core.

## Interface
- `ADDR_W`, default 28: address width.
- `DATA_W`, default 32: data width; must be a power of two and at least 8.
- `ID_W`, default 4: transaction ID width.
- `DEPTH`, default 1024: number of words; must be a power of two.
- `READ_LAT`, default 1: cycles from AR handshake to first `rvalid`; must be at least 1.

Ports:
- `clk` in 1: clock, rising edge.
- `aresetn` in 1: asynchronous active-low reset.
- `s_axi_awid` / `awaddr` / `awlen` / `awsize` / `awburst` in ID_W/ADDR_W/8/3/2: write address.
- `s_axi_awvalid` in 1, `s_axi_awready` out 1: write address handshake.
- `s_axi_wdata` in DATA_W: write data.
- `s_axi_wstrb` in DATA_W/8: byte enables.
- `s_axi_wlast` in 1: last write beat flag.
- `s_axi_wvalid` in 1, `s_axi_wready` out 1: write data handshake.
- `s_axi_bid` out ID_W: response ID.
- `s_axi_bresp` out 2: write response.
- `s_axi_bvalid` out 1, `s_axi_bready` in 1: write response handshake.
- `s_axi_arid` / `araddr` / `arlen` / `arsize` / `arburst` in ID_W/ADDR_W/8/3/2: read address.
- `s_axi_arvalid` in 1, `s_axi_arready` out 1: read address handshake.
- `s_axi_rid` out ID_W: read ID.
- `s_axi_rdata` out DATA_W: read data.
- `s_axi_rresp` out 2: read response.
- `s_axi_rlast` out 1: last read beat flag.
- `s_axi_rvalid` out 1, `s_axi_rready` in 1: read data handshake.

## Operation

General:
- Word index is `addr[ADDR_W-1:log2(DATA_W/8)]` modulo `DEPTH`; low address bits are ignored.
- `awsize`/`arsize` are treated as full width.
- Burst type FIXED (0) keeps the index constant. INCR (1), WRAP (2) and reserved (3) all increment the index by 1 per beat, wrapping at `DEPTH`.
- Cache, prot, qos and lock signals are not ported.
- Memory contents are not reset.

Read FSM, R_IDLE → R_LAT → R_DATA → R_IDLE:
- R_IDLE: `arready`=1. On AR handshake, latch id, index and len, load the latency counter with `READ_LAT`, then go to R_LAT.
- R_LAT: the counter decrements each cycle. At 1, present beat 0 with `rvalid`=1 and go to R_DATA.
- R_DATA: `rdata`, `rid` and `rresp` stay stable while `rvalid & !rready`. On each handshake, advance the index and present the next beat in the following cycle with no bubble. `rlast`=1 on beat `len`.
- Handshake on the last beat: `rvalid`=0 and return to R_IDLE.

Write FSM, W_IDLE → W_DATA → W_RESP → W_IDLE:
- W_IDLE: `awready`=1. On AW handshake, latch id, index and len, then go to W_DATA.
- W_DATA: `wready`=1. Each handshake writes the bytes enabled by `wstrb`, then advances the index.
- The beat counter is authoritative and `wlast` is ignored. The handshake on beat `len` goes to W_RESP.
- W_RESP: `bvalid`=1 and `bresp` is held. On `bready`, go to W_IDLE.
- The read and write FSMs are fully independent and may be active at once.

## Timing
- Reset values: `arready`=0, `awready`=0, `wready`=0, `rvalid`=0, `rlast`=0, `bvalid`=0; `rdata`, `rid`, `rresp`, `bid`, `bresp` are all 0.
- `arready` and `awready` rise in the first cycle after `aresetn` deasserts.
- First `rvalid` comes exactly `READ_LAT` cycles after the AR handshake edge. Single beats then repeat every cycle under constant `rready`.
- `arready` stays 0 from the AR handshake until the cycle after the last R handshake; only one read is outstanding.
- `awready` stays 0 from the AW handshake until the cycle after the B handshake.
- `bvalid` rises the cycle after the last W handshake.
- A read and a write to the same word in the same cycle: the read returns the old data.
- Reset asserted mid-burst: all outputs take their reset values immediately, both FSMs go to IDLE, and in-flight transactions are discarded. Words already written are kept.
- `awlen`/`arlen` = 255 gives 256 beats. The index wraps from `DEPTH-1` to 0 inside a burst.

## Configuration
- `AXI_SLAVE_MEM_RANGE_ERR_EN` defined: the address range check is compiled in.
  - A burst is out of range if any beat's index, computed without modulo, is `>= DEPTH`.
  - Out-of-range reads return `rdata`=0 and `rresp`=SLVERR (2) on every beat.
  - Out-of-range writes are dropped for the whole burst, with `bresp`=SLVERR.
  - Beat count and handshakes are unchanged.
- Undefined: addresses alias modulo `DEPTH` and responses are always OKAY (0).

## Test plan
- Reset release, then write single beat: addr 0x10, data 0xDEADBEEF, strb 0xF, then read addr 0x10 with `READ_LAT`=3. Required: `bresp`=0; `rvalid` rises 3 cycles after AR; `rdata`=0xDEADBEEF, `rlast`=1, `rid` equals `arid`.
- INCR write, len=3, at addr 0x100, data 1..4, then INCR read of the same range with `rready` toggling 1,0,1,0. Required: data 1,2,3,4; `rlast` only on the 4th beat; `rdata` held during stalls.
- Byte strobes: write 0xFFFFFFFF, then 0x00000000 with strb 0x5. Required: read returns 0xFF00FF00.
- Concurrent read burst (len=7) and write burst (len=7) to disjoint ranges. Required: both complete; `arready` and `awready` each return 1 the cycle after their own final handshake.
- Reset pulse during beat 2 of an 8-beat read. Required: `rvalid`=0 immediately and `arready`=1 one cycle after release; a new read then returns correct data.
- With `AXI_SLAVE_MEM_RANGE_ERR_EN` defined and `DEPTH`=1024, a write to index 1023 with len=1. Required: `bresp`=2, and word 1023 is unchanged.
